// File: rtl/frame_overlap_buffer.sv
// Circular sample buffer that replays overlapping frames of N samples, each
// frame starting HOP samples after the previous one.
module frame_overlap_buffer #(
    parameter int Q_DATA = 15,
    parameter int N      = 256,
    parameter int HOP    = 128,
    localparam int DEPTH = 2 * N,
    localparam int AW    = $clog2(DEPTH),
    localparam int P     = AW + 1,
    localparam int IW    = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic signed [Q_DATA:0] data_in,
    input  logic                rd_en,
    output logic                valid_out,
    output logic signed [Q_DATA:0] data_out,
    output logic                last_out,
    output logic                frame_ready,
    output logic [P-1:0]        occupancy,
    output logic                overflow,
    output logic                underflow
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state;
    logic signed [Q_DATA:0] mem [DEPTH];
    logic [P-1:0]           wr_ptr;
    logic [P-1:0]           rd_base;
    logic [IW-1:0]          rd_idx;
    logic [AW-1:0]          rd_addr;
    logic                   wr_accept;
    logic                   enough;
    logic                   rd_last;

    // Pointers carry one extra bit so a full buffer (DEPTH) differs from empty.
    assign occupancy   = wr_ptr - rd_base;
    assign enough      = (occupancy >= P'(N));
    assign wr_accept   = valid_in && (occupancy < P'(DEPTH));
    assign rd_last     = (rd_idx == IW'(N - 1));
    assign rd_addr     = rd_base[AW-1:0] + AW'(rd_idx);
    assign frame_ready = (state == IDLE) && enough;

    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_base   <= '0;
            rd_idx    <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (valid_in) begin
                overflow <= 1'b1;
            end

            valid_out <= 1'b0;
            last_out  <= 1'b0;
            underflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_en) begin
                        if (enough) begin
                            valid_out <= 1'b1;
                            data_out  <= mem[rd_addr];
                            rd_idx    <= IW'(1);
                            state     <= STREAM;
                        end else begin
                            underflow <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // rd_base only advances once the whole frame has been read,
                    // which keeps the in-progress frame safe from new writes.
                    if (rd_en) begin
                        valid_out <= 1'b1;
                        data_out  <= mem[rd_addr];
                        if (rd_last) begin
                            last_out <= 1'b1;
                            rd_base  <= rd_base + P'(HOP);
                            rd_idx   <= '0;
                            state    <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_overlap_buffer.sv
// Self-checking bench for frame_overlap_buffer with N=8, HOP=4, 16-bit samples.
module tb_frame_overlap_buffer;

    localparam int QD  = 15;
    localparam int NN  = 8;
    localparam int HP  = 4;
    localparam int DEP = 2 * NN;
    localparam int PW  = $clog2(DEP) + 1;

    localparam int OP_WR  = 0;
    localparam int OP_RD  = 1;
    localparam int OP_UND = 2;
    localparam int OP_RST = 3;

    typedef struct {
        int op;
        int cnt;
        int occ;
        bit fr;
        bit ovf;
    } step_t;

    logic                clk;
    logic                reset;
    logic                valid_in;
    logic signed [QD:0]  data_in;
    logic                rd_en;
    logic                valid_out;
    logic signed [QD:0]  data_out;
    logic                last_out;
    logic                frame_ready;
    logic [PW-1:0]       occupancy;
    logic                overflow;
    logic                underflow;

    int total = 0;
    int bad   = 0;

    logic [QD+1:0]      exp_q[$];
    logic signed [QD:0] samples[$];
    int                 base = 0;
    int                 wval = 0;
    logic [QD+1:0]      mon_e;
    step_t              steps[15];

    frame_overlap_buffer #(.Q_DATA(QD), .N(NN), .HOP(HP)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .rd_en(rd_en), .valid_out(valid_out), .data_out(data_out),
        .last_out(last_out), .frame_ready(frame_ready), .occupancy(occupancy),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every read output must match the head of the queue.
    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("data", int'(data_out), int'($signed(mon_e[QD:0])));
                check("last", int'(last_out), int'(mon_e[QD+1]));
            end
        end else begin
            check("last_idle", int'(last_out), 0);
        end
    end

    task automatic model_clear();
        samples.delete();
        exp_q.delete();
        base = 0;
        wval = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rd_en    = 1'b0;
        valid_in = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_write(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            data_in  = QD'(wval);
            if (samples.size() - base < DEP) samples.push_back(data_in);
            wval++;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic do_read_frame();
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back({(i == NN - 1), samples[base + i]});
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        base += HP;
        tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("underflow_pulse", int'(underflow), 1);
        check("underflow_novalid", int'(valid_out), 0);
        tick();
        check("underflow_clear", int'(underflow), 0);
        check("underflow_novalid2", int'(valid_out), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, int'(valid_out), 0);
        check({tag, "_last"}, int'(last_out), 0);
        check({tag, "_data"}, int'(data_out), 0);
        check({tag, "_occ"}, int'(occupancy), 0);
        check({tag, "_fr"}, int'(frame_ready), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_unf"}, int'(underflow), 0);
    endtask

    initial begin
        steps[0]  = '{OP_WR,  8,  8, 1, 0};
        steps[1]  = '{OP_RD,  0,  4, 0, 0};
        steps[2]  = '{OP_WR,  4,  8, 1, 0};
        steps[3]  = '{OP_RD,  0,  4, 0, 0};
        steps[4]  = '{OP_WR,  4,  8, 1, 0};
        steps[5]  = '{OP_RD,  0,  4, 0, 0};
        steps[6]  = '{OP_WR,  1,  5, 0, 0};
        steps[7]  = '{OP_UND, 0,  5, 0, 0};
        steps[8]  = '{OP_WR, 11, 16, 1, 0};
        steps[9]  = '{OP_WR,  1, 16, 1, 1};
        steps[10] = '{OP_RD,  0, 12, 1, 1};
        steps[11] = '{OP_RST, 0,  0, 0, 0};
        steps[12] = '{OP_WR, 17, 16, 1, 1};
        steps[13] = '{OP_RD,  0, 12, 1, 1};
        steps[14] = '{OP_RD,  0,  8, 1, 1};

        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        rd_en    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_zero_outputs("reset");

        foreach (steps[s]) begin
            case (steps[s].op)
                OP_WR:   do_write(steps[s].cnt);
                OP_RD:   do_read_frame();
                OP_UND:  do_underflow();
                default: do_reset();
            endcase
            check($sformatf("step%0d_occ", s), int'(occupancy), steps[s].occ);
            check($sformatf("step%0d_fr", s), int'(frame_ready), int'(steps[s].fr));
            check($sformatf("step%0d_ovf", s), int'(overflow), int'(steps[s].ovf));
        end

        // Gapped read with a write landing on the frame's final read.
        do_reset();
        do_write(8);
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back({(i == NN - 1), samples[base + i]});
            rd_en = 1'b1;
            if (i == NN - 1) begin
                valid_in = 1'b1;
                data_in  = QD'(wval);
                samples.push_back(data_in);
                wval++;
            end
            tick();
            rd_en    = 1'b0;
            valid_in = 1'b0;
            tick();
            check("gap_valid", int'(valid_out), 0);
            check("gap_hold", int'(data_out), int'(samples[base + i]));
        end
        base += HP;
        check("gap_drain", exp_q.size(), 0);
        check("gap_occ", int'(occupancy), 5);
        check("gap_fr", int'(frame_ready), 0);

        // Reset in the middle of a frame, then a clean frame afterwards.
        do_write(3);
        check("mid_occ", int'(occupancy), 8);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, samples[base + i]});
            rd_en = 1'b1;
            tick();
        end
        do_reset();
        check_zero_outputs("midreset");
        do_write(8);
        do_read_frame();
        check("post_reset_occ", int'(occupancy), 4);

        repeat (2) tick();
        check("final_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
